// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared width derivation and constants for the TDC time-of-arrival encoder
package tdc_pkg;

    localparam int BUBBLE_SAT = 3;

    function automatic int fineWidth(input int taps);
        return $clog2(2 * taps + 1);
    endfunction

    // Reserved fine code that marks an encode error: all ones of the fine width.
    function automatic int errCode(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/tdc_fine_encoder.sv
// rtl/tdc_fine_encoder.sv - combinational thermometer-to-binary fine encoder with bubble counting
module tdc_fine_encoder
    import tdc_pkg::*;
#(
    parameter int FINE_TAPS = 63,
    parameter int FINE_W    = fineWidth(FINE_TAPS)
) (
    input  logic [FINE_TAPS-1:0] taps,
    input  logic [1:0]           level,
    output logic [FINE_W-1:0]    fine,
    output logic [1:0]           bubble,
    output logic                 error
);

    localparam logic [FINE_W-1:0] ERR_CODE = FINE_W'(errCode(FINE_W));
    localparam logic [FINE_W-1:0] NTAPS    = FINE_W'(FINE_TAPS);
    localparam logic [FINE_W-1:0] ONE      = FINE_W'(1);

    logic              s;
    logic [FINE_W-1:0] pos;
    logic [FINE_W-1:0] nb;
    logic [FINE_W-1:0] rawFine;

    always_comb begin
        s   = taps[0];
        pos = NTAPS;
        // Scan downwards so the last hit is the lowest transition index.
        for (int i = FINE_TAPS - 1; i >= 1; i--) begin
            if (taps[i] != s) pos = FINE_W'(i);
        end
        nb = '0;
        for (int i = 1; i < FINE_TAPS; i++) begin
            if (FINE_W'(i) >= pos && taps[i] == s) nb = nb + ONE;
        end
        rawFine = s ? (pos - ONE) : (NTAPS + pos - ONE);
        error   = (nb > FINE_W'(level)) || (rawFine == ERR_CODE);
        fine    = error ? ERR_CODE : rawFine;
        bubble  = (nb > FINE_W'(BUBBLE_SAT)) ? 2'(BUBBLE_SAT) : nb[1:0];
    end

endmodule

// File: rtl/tdc_toa_encoder_pipe.sv
// rtl/tdc_toa_encoder_pipe.sv - three-stage TDC time-of-arrival encoder with coarse correction and stats
module tdc_toa_encoder_pipe
    import tdc_pkg::*;
#(
    parameter int FINE_TAPS = 63,
    parameter int COARSE_W  = 3,
    parameter int FINE_W    = fineWidth(FINE_TAPS),
    parameter int STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FINE_TAPS-1:0] in_taps,
    input  logic [COARSE_W-1:0]  in_cnt_a,
    input  logic [COARSE_W-1:0]  in_cnt_b,
    input  logic [1:0]           cfg_level,
    input  logic [FINE_W-1:0]    cfg_offset,
    input  logic                 cfg_raw,
    input  logic                 stat_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COARSE_W-1:0]  out_coarse,
    output logic [FINE_W-1:0]    out_fine,
    output logic [1:0]           out_bubble,
    output logic                 out_error,
    output logic [STAT_W-1:0]    stat_hits,
    output logic [STAT_W-1:0]    stat_errs
);

    localparam logic [FINE_W:0]   PHASE_MOD = (FINE_W+1)'(2 * FINE_TAPS + 1);
    localparam logic [FINE_W:0]   PHASE_LIM = (FINE_W+1)'(FINE_TAPS - 1);
    localparam logic [STAT_W-1:0] STAT_MAX  = '1;

    logic                 s1Valid, s2Valid;
    logic [FINE_TAPS-1:0] s1Taps;
    logic [COARSE_W-1:0]  s1CntA, s1CntB, s2CntA, s2CntB;
    logic [1:0]           s1Level;
    logic [FINE_W-1:0]    s1Offset, s2Offset;
    logic                 s1Raw, s2Raw;
    logic [FINE_W-1:0]    s2Fine;
    logic [1:0]           s2Bubble;
    logic                 s2Error;

    logic [FINE_W-1:0]    encFine;
    logic [1:0]           encBubble;
    logic                 encError;

    logic                 ready2, ready3;
    logic [FINE_W:0]      phase;
    logic                 selA;
    logic [COARSE_W-1:0]  nextCoarse;

    tdc_fine_encoder #(
        .FINE_TAPS (FINE_TAPS),
        .FINE_W    (FINE_W)
    ) u_fine_encoder (
        .taps   (s1Taps),
        .level  (s1Level),
        .fine   (encFine),
        .bubble (encBubble),
        .error  (encError)
    );

    assign ready3   = !out_valid || out_ready;
    assign ready2   = !s2Valid || ready3;
    assign in_ready = !s1Valid || ready2;

    // s2Fine is already forced to the error code, so erroneous hits select on that value.
    assign phase      = ({1'b0, s2Offset} + {1'b0, s2Fine}) % PHASE_MOD;
    assign selA       = phase > PHASE_LIM;
    assign nextCoarse = s2Raw ? s2CntA : (selA ? s2CntA - COARSE_W'(1) : s2CntB);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1Valid    <= 1'b0;
            s1Taps     <= '0;
            s1CntA     <= '0;
            s1CntB     <= '0;
            s1Level    <= '0;
            s1Offset   <= '0;
            s1Raw      <= 1'b0;
            s2Valid    <= 1'b0;
            s2Fine     <= '0;
            s2Bubble   <= '0;
            s2Error    <= 1'b0;
            s2CntA     <= '0;
            s2CntB     <= '0;
            s2Offset   <= '0;
            s2Raw      <= 1'b0;
            out_valid  <= 1'b0;
            out_coarse <= '0;
            out_fine   <= '0;
            out_bubble <= '0;
            out_error  <= 1'b0;
            stat_hits  <= '0;
            stat_errs  <= '0;
        end else begin
            if (in_ready) begin
                s1Valid <= in_valid;
                if (in_valid) begin
                    s1Taps   <= in_taps;
                    s1CntA   <= in_cnt_a;
                    s1CntB   <= in_cnt_b;
                    s1Level  <= cfg_level;
                    s1Offset <= cfg_offset;
                    s1Raw    <= cfg_raw;
                end
            end
            if (ready2) begin
                s2Valid <= s1Valid;
                if (s1Valid) begin
                    s2Fine   <= encFine;
                    s2Bubble <= encBubble;
                    s2Error  <= encError;
                    s2CntA   <= s1CntA;
                    s2CntB   <= s1CntB;
                    s2Offset <= s1Offset;
                    s2Raw    <= s1Raw;
                end
            end
            if (ready3) begin
                out_valid <= s2Valid;
                if (s2Valid) begin
                    out_coarse <= nextCoarse;
                    out_fine   <= s2Fine;
                    out_bubble <= s2Bubble;
                    out_error  <= s2Error;
                end
            end
            if (stat_clr) begin
                stat_hits <= '0;
                stat_errs <= '0;
            end else begin
                if (in_valid && in_ready && stat_hits != STAT_MAX)
                    stat_hits <= stat_hits + STAT_W'(1);
                if (ready3 && s2Valid && s2Error && stat_errs != STAT_MAX)
                    stat_errs <= stat_errs + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tdc_toa_encoder_pipe.sv
// tb/tb_tdc_toa_encoder_pipe.sv - randomized self-checking bench for tdc_toa_encoder_pipe
module tb_tdc_toa_encoder_pipe;

    localparam int N  = 63;
    localparam int FW = 7;
    localparam int CW = 3;
    localparam int SW = 4;

    typedef struct packed {
        logic [N-1:0]  taps;
        logic [CW-1:0] a;
        logic [CW-1:0] b;
        logic [1:0]    lvl;
        logic [FW-1:0] off;
        logic          raw;
    } smp_t;

    typedef struct packed {
        logic [CW-1:0] coarse;
        logic [FW-1:0] fine;
        logic [1:0]    bubble;
        logic          err;
    } res_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_taps;
    logic [CW-1:0] in_cnt_a, in_cnt_b;
    logic [1:0]    cfg_level;
    logic [FW-1:0] cfg_offset;
    logic          cfg_raw;
    logic          stat_clr;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_coarse;
    logic [FW-1:0] out_fine;
    logic [1:0]    out_bubble;
    logic          out_error;
    logic [SW-1:0] stat_hits, stat_errs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdc_toa_encoder_pipe #(
        .FINE_TAPS (N),
        .COARSE_W  (CW),
        .STAT_W    (SW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_taps    (in_taps),
        .in_cnt_a   (in_cnt_a),
        .in_cnt_b   (in_cnt_b),
        .cfg_level  (cfg_level),
        .cfg_offset (cfg_offset),
        .cfg_raw    (cfg_raw),
        .stat_clr   (stat_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_coarse (out_coarse),
        .out_fine   (out_fine),
        .out_bubble (out_bubble),
        .out_error  (out_error),
        .stat_hits  (stat_hits),
        .stat_errs  (stat_errs)
    );

    // Reference: run length of the leading symbol gives p; bubbles are the remaining copies of it.
    function automatic res_t model(input smp_t x);
        res_t r;
        int run, total, nb, f, fe, ph;
        logic s;
        s = x.taps[0];
        run = 1;
        while (run < N && x.taps[run] == s) run++;
        total = 0;
        for (int i = 0; i < N; i++) if (x.taps[i] == s) total++;
        nb = total - run;
        f  = s ? run - 1 : N + run - 1;
        r.err = (nb > int'(x.lvl)) || (f == 127);
        fe = r.err ? 127 : f;
        ph = (int'(x.off) + fe) % (2 * N + 1);
        r.fine   = FW'(fe);
        r.bubble = (nb > 3) ? 2'd3 : 2'(nb);
        if (x.raw)        r.coarse = x.a;
        else if (ph > N-1) r.coarse = x.a - 3'd1;
        else              r.coarse = x.b;
        return r;
    endfunction

    function automatic smp_t mk(input logic [N-1:0] taps, input logic [CW-1:0] a, input logic [CW-1:0] b,
                                input logic [1:0] lvl, input logic [FW-1:0] off, input logic raw);
        smp_t x;
        x.taps = taps; x.a = a; x.b = b; x.lvl = lvl; x.off = off; x.raw = raw;
        return x;
    endfunction

    function automatic smp_t randSample();
        smp_t x;
        logic s;
        int run, flips, idx;
        s   = 1'($urandom % 2);
        run = $urandom_range(1, N);
        for (int i = 0; i < N; i++) x.taps[i] = (i < run) ? s : ~s;
        flips = $urandom_range(0, 4);
        for (int k = 0; k < flips; k++) begin
            idx = $urandom_range(1, N - 1);
            x.taps[idx] = ~x.taps[idx];
        end
        x.a   = CW'($urandom);
        x.b   = CW'($urandom);
        x.lvl = 2'($urandom);
        x.off = FW'($urandom_range(0, 127));
        x.raw = ($urandom % 4) == 0;
        return x;
    endfunction

    function automatic res_t curOut();
        res_t r;
        r.coarse = out_coarse; r.fine = out_fine; r.bubble = out_bubble; r.err = out_error;
        return r;
    endfunction

    task automatic drive(input smp_t x);
        in_taps = x.taps; in_cnt_a = x.a; in_cnt_b = x.b;
        cfg_level = x.lvl; cfg_offset = x.off; cfg_raw = x.raw;
    endtask

    task automatic runOne(input smp_t x, output res_t got, output int lat);
        @(negedge clk);
        drive(x);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        got = curOut();
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stat_clr = 1'b0;
        drive(mk('0, 3'd0, 3'd0, 2'd0, 7'd0, 1'b0));
        #1;
        checks++;
        if (out_valid !== 1'b0 || curOut() !== '0) begin
            errors++; $display("FAIL reset_outputs: got v=%b %h want v=0 0", out_valid, curOut());
        end
        checks++;
        if (stat_hits !== '0 || stat_errs !== '0) begin
            errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_hits, stat_errs);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        res_t got; int lat;
        runOne(mk(63'hF, 3'd5, 3'd2, 2'd0, 7'd0, 1'b0), got, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d want 3", lat); end
        checks++;
        if (got !== res_t'({3'd2, 7'd3, 2'd0, 1'b0})) begin
            errors++; $display("FAIL basic_sel_b: got %h want %h", got, res_t'({3'd2, 7'd3, 2'd0, 1'b0}));
        end
        runOne(mk(~63'h3FF, 3'd0, 3'd5, 2'd0, 7'd0, 1'b0), got, lat);
        checks++;
        if (got !== res_t'({3'd7, 7'd72, 2'd0, 1'b0})) begin
            errors++; $display("FAIL basic_sel_a_wrap: got %h want %h", got, res_t'({3'd7, 7'd72, 2'd0, 1'b0}));
        end
    endtask

    task automatic test_bubble();
        res_t got; int lat;
        logic [N-1:0] t;
        t = 63'hF;
        t[20] = 1'b1;
        t[40] = 1'b1;
        runOne(mk(t, 3'd1, 3'd6, 2'd1, 7'd0, 1'b0), got, lat);
        checks++;
        if (got !== res_t'({3'd6, 7'd127, 2'd2, 1'b1})) begin
            errors++; $display("FAIL bubble_l1_error: got %h want %h", got, res_t'({3'd6, 7'd127, 2'd2, 1'b1}));
        end
        runOne(mk(t, 3'd1, 3'd6, 2'd2, 7'd0, 1'b0), got, lat);
        checks++;
        if (got !== res_t'({3'd6, 7'd3, 2'd2, 1'b0})) begin
            errors++; $display("FAIL bubble_l2_ok: got %h want %h", got, res_t'({3'd6, 7'd3, 2'd2, 1'b0}));
        end
    endtask

    task automatic test_raw();
        res_t got; int lat;
        runOne(mk(~63'hFF, 3'd4, 3'd1, 2'd0, 7'd0, 1'b1), got, lat);
        checks++;
        if (got !== res_t'({3'd4, 7'd70, 2'd0, 1'b0})) begin
            errors++; $display("FAIL raw_bypass: got %h want %h", got, res_t'({3'd4, 7'd70, 2'd0, 1'b0}));
        end
    endtask

    task automatic test_stream(input int count, input bit toggle);
        smp_t samples[$];
        res_t expq[$];
        res_t held, exp;
        logic stalled;
        int sent, got, occ, cyc;
        bit acc, fire;
        for (int i = 0; i < count; i++) samples.push_back(randSample());
        sent = 0; got = 0; occ = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < count && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            out_ready = toggle ? 1'(cyc % 2) : 1'($urandom % 2);
            if (sent < count) begin drive(samples[sent]); in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            checks++;
            if (in_ready !== !(occ == 3 && !out_ready)) begin
                errors++; $display("FAIL stream_in_ready: got %b occ=%0d out_ready=%b", in_ready, occ, out_ready);
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || curOut() !== held) begin
                    errors++; $display("FAIL stream_stall_hold: got v=%b %h want v=1 %h", out_valid, curOut(), held);
                end
            end
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                exp = expq.pop_front();
                checks++;
                if (curOut() !== exp) begin
                    errors++; $display("FAIL stream_data[%0d]: got %h want %h", got, curOut(), exp);
                end
                got++;
                occ--;
            end
            stalled = out_valid && !out_ready;
            held    = curOut();
            if (acc) begin
                expq.push_back(model(samples[sent]));
                sent++;
                occ++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (got !== count) begin
            errors++; $display("FAIL stream_count: got %0d want %0d", got, count);
        end
    endtask

    task automatic test_stats();
        smp_t x;
        int errCount;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        errCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            x = randSample();
            x.lvl = 2'd0;
            drive(x);
            in_valid = 1'b1;
            if (model(x).err) errCount++;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (stat_hits !== 4'd15) begin
            errors++; $display("FAIL stats_hits_sat: got %0d want 15", stat_hits);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (int'(stat_errs) !== ((errCount > 15) ? 15 : errCount)) begin
            errors++; $display("FAIL stats_errs: got %0d want %0d", stat_errs, (errCount > 15) ? 15 : errCount);
        end
        drive(randSample());
        in_valid = 1'b1;
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (stat_hits !== '0 || stat_errs !== '0) begin
            errors++; $display("FAIL stats_clr_priority: got %0d/%0d want 0/0", stat_hits, stat_errs);
        end
        @(negedge clk);
        in_valid = 1'b0;
        stat_clr = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(randSample());
            in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL full_stall: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || curOut() !== '0 || stat_hits !== '0) begin
            errors++; $display("FAIL midstream_reset: got v=%b rdy=%b out=%h hits=%0d want 0 1 0 0",
                               out_valid, in_ready, curOut(), stat_hits);
        end
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL post_reset_stale[%0d]: got v=%b want 0", i, out_valid);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_bubble();
        test_raw();
        test_stream(10, 1'b1);
        test_stream(80, 1'b0);
        test_stats();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_toa_encoder_pipe.md
# tdc_toa_encoder_pipe

Pipelined, parametrised time-of-arrival encoder for the TDC. It converts one delay-line sample of FINE_TAPS bits plus two ripple-counter snapshots into a binary fine code and a corrected coarse phase. It tolerates configurable bubble errors and supports a raw-bypass mode. The block sits between the TDC sampling flops and the hit-packing logic, with valid/ready flow control and saturating hit/error statistics counters.

## Interface
- FINE_TAPS, 63: delay-line taps sampled per hit (N); must be ≥ 3.
- COARSE_W, 3: ripple-counter width.
- FINE_W, $clog2(2*FINE_TAPS+1): fine code width (7 for N=63).
- STAT_W, 16: statistics counter width.
- clk  in  1  single system clock.
- rstn  in  1  reset, asynchronous and active-low.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_taps  in  FINE_TAPS  delay-line sample; bit 0 is the first tap.
- in_cnt_a  in  COARSE_W  counter A (positive edge, last tap).
- in_cnt_b  in  COARSE_W  counter B (negative edge, last tap).
- cfg_level  in  2  bubble tolerance L (0..3).
- cfg_offset  in  FINE_W  phase offset for A/B selection.
- cfg_raw  in  1  1 = bypass correction.
- stat_clr  in  1  synchronous clear of statistics.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_coarse  out  COARSE_W  corrected coarse phase.
- out_fine  out  FINE_W  fine code.
- out_bubble  out  2  bubble count, saturated at 3.
- out_error  out  1  encode error.
- stat_hits  out  STAT_W  accepted samples, saturating.
- stat_errs  out  STAT_W  samples with out_error=1, saturating.

## Operation
- Fine encode, N = FINE_TAPS:
  - Let s = in_taps[0].
  - p = lowest index i ≥ 1 with in_taps[i] != s; p = N if none.
  - f = p−1 when s = 1; f = N+p−1 when s = 0. Range 0..2N−1.
- Bubble count nb: number of bits in in_taps[p..N−1] equal to s. out_bubble = min(nb, 3).
- Error: nb > cfg_level forces out_fine = all ones (2^FINE_W−1) and out_error = 1. f = 2^FINE_W−1 can also occur naturally (only if 2N−1 = 2^FINE_W−1); it is flagged as an error too.
- Coarse correction when cfg_raw = 0:
  - sel_a = ((cfg_offset + f) mod (2N+1)) > N−1.
  - out_coarse = sel_a ? in_cnt_a − 1 : in_cnt_b, modulo 2^COARSE_W (0 − 1 → all ones).
  - On error, the coarse value is still computed, using f = all ones.
- Raw mode (cfg_raw = 1): out_coarse = in_cnt_a and out_fine = f, uncorrected. Bubble and error outputs still apply.
- Config inputs are sampled together with the data in stage 1. Mid-stream changes affect only later samples.
- Statistics:
  - stat_hits increments on each in_valid && in_ready.
  - stat_errs increments on each stage-3 load whose error is 1.
  - Both hold at 2^STAT_W−1.
  - stat_clr zeroes both and has priority over a simultaneous increment.

## Timing
- Three register stages:
  - S1 captures inputs and config.
  - S2 holds f, p, nb and the error flag.
  - S3 holds the final outputs.
- Latency is 3 cycles from accept to out_valid with no backpressure. Throughput is 1 sample per cycle.
- Each stage has a valid bit. A stage advances when its successor is empty or advancing. in_ready = !S1.valid || S1 advances, i.e. standard full-throughput stall; no combinational in_valid→out_valid path.
- out_valid holds with stable data until out_ready is sampled high. No sample is dropped or duplicated.
- Reset: all valid bits, out_coarse, out_fine, out_bubble, out_error, stat_hits and stat_errs are 0; in_ready = 1 after reset. Assertion mid-stream discards all in-flight samples immediately.
- Full pipeline with out_ready = 0: in_ready drops in the same cycle the third sample is held.

## Structure
- Shared package tdc_pkg holds:
  - the error-code constant function (all ones of FINE_W);
  - the FINE_W derivation;
  - the bubble-saturation value 3.
- Sub-module tdc_fine_encoder: combinational, parametrised on FINE_TAPS. Computes f, nb and the error from taps and level. Instanced between S1 and S2.
- Coarse correction and statistics live in the top module.

## Test plan
- N=63, in_taps = 0x0000_0000_0000_000F (bits 0..3 set), L=0, offset 0, cnt_a=5, cnt_b=2 → f=3, sel_a=0, out_coarse=2, out_fine=3, out_bubble=0, out_error=0, out_valid 3 cycles after accept.
- in_taps with bit0=0 and bits 0..9 zero, rest ones; offset 0, cnt_a=0 → f=72, sel_a=1, out_coarse=7 (wrap), out_fine=72.
- Taps ones 0..3 with stray ones at bits 20 and 40:
  - L=1 → out_error=1, out_fine=127, out_bubble=2.
  - L=2 → f=3, out_error=0, out_bubble=2.
- Stream of 10 back-to-back samples; out_ready toggles 1/0 every cycle → all 10 out in order, unchanged while stalled, in_ready=0 only when full.
- cfg_raw=1, f=70, cnt_a=4 → out_coarse=4, out_fine=70.
- STAT_W=4, 20 accepted hits → stat_hits sticks at 15. stat_clr asserted together with a hit → 0. rstn pulsed low mid-stream → out_valid=0 immediately and no stale outputs after release.
